// File: rtl/seq_mulneg_disp_if.sv
// Handshake and display bus for the sequential signed multiplier.
// The master drives operands and start; the slave returns status, product and segment drive.
interface seq_mulneg_disp_if #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned DIGITS = 2
);
  logic                   start;
  logic [WIDTH-1:0]       a;
  logic [WIDTH-1:0]       b;
  logic                   busy;
  logic                   done;
  logic [2*WIDTH-1:0]     product;
  logic [6:0]             seg;
  logic                   dp;
  logic [DIGITS-1:0]      an;

  modport master (
    output start, a, b,
    input  busy, done, product, seg, dp, an
  );

  modport slave (
    input  start, a, b,
    output busy, done, product, seg, dp, an
  );
endinterface

// File: rtl/seq_mulneg_disp.sv
// Iterative signed multiplier (shift-add on magnitudes, one bit per cycle) whose last
// product magnitude is scanned as hex digits across a multiplexed 7-segment bank.
module seq_mulneg_disp #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned DIGITS      = 2,
  parameter int unsigned REFRESH_DIV = 4,
  parameter bit          BLANK       = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  seq_mulneg_disp_if.slave bus
);

  localparam int unsigned PW   = 2 * WIDTH;
  localparam int unsigned MagW = 4 * DIGITS;
  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned RefW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);
  localparam logic [RefW-1:0] LastRef = RefW'(REFRESH_DIV - 1);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DIGITS - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StFin} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  mcand_q, mcand_d;
  logic [WIDTH-1:0]  mplier_q, mplier_d;
  logic              neg_q, neg_d;
  logic [PW-1:0]     acc_q, acc_d;
  logic [PW-1:0]     product_q, product_d;
  logic [PW-1:0]     mag_q, mag_d;
  logic              sign_q, sign_d;
  logic [RefW-1:0]   ref_q, ref_d;
  logic [IdxW-1:0]   idx_q, idx_d;

  logic [WIDTH-1:0]  abs_a, abs_b;
  logic [PW-1:0]     addend, acc_sum;
  logic              busy, done;

  // Magnitudes fit in WIDTH bits unsigned, including the most negative operand.
  assign abs_a   = bus.a[WIDTH-1] ? (~bus.a + 1'b1) : bus.a;
  assign abs_b   = bus.b[WIDTH-1] ? (~bus.b + 1'b1) : bus.b;
  assign addend  = mplier_q[cnt_q] ? ({{WIDTH{1'b0}}, mcand_q} << cnt_q) : '0;
  assign acc_sum = acc_q + addend;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    neg_d     = neg_q;
    acc_d     = acc_q;
    product_d = product_q;
    mag_d     = mag_q;
    sign_d    = sign_q;
    busy      = 1'b0;
    done      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          mcand_d  = abs_a;
          mplier_d = abs_b;
          neg_d    = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = StCalc;
        end
      end
      StCalc: begin
        busy  = 1'b1;
        acc_d = acc_sum;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastCnt) begin
          product_d = neg_q ? -acc_sum : acc_sum;
          mag_d     = acc_sum;
          // Suppress the sign on a zero result so the display never shows -0.
          sign_d    = neg_q & (|acc_sum);
          state_d   = StFin;
        end
      end
      StFin: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Scan runs free of the FSM.
  always_comb begin
    ref_d = ref_q;
    idx_d = idx_q;
    if (ref_q == LastRef) begin
      ref_d = '0;
      idx_d = (idx_q == LastIdx) ? '0 : idx_q + 1'b1;
    end else begin
      ref_d = ref_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      neg_q     <= 1'b0;
      acc_q     <= '0;
      product_q <= '0;
      mag_q     <= '0;
      sign_q    <= 1'b0;
      ref_q     <= '0;
      idx_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      neg_q     <= neg_d;
      acc_q     <= acc_d;
      product_q <= product_d;
      mag_q     <= mag_d;
      sign_q    <= sign_d;
      ref_q     <= ref_d;
      idx_q     <= idx_d;
    end
  end

  logic [MagW-1:0]   mag_ext;
  logic [3:0]        nib;
  logic [DIGITS-1:0] zero_above;
  logic              zero_run;
  logic              blank;
  logic [6:0]        seg;
  logic [DIGITS-1:0] an;

  assign mag_ext = MagW'(mag_q);
  assign nib     = 4'(mag_ext >> {idx_q, 2'b00});

  // zero_above[i] is set when digit i and every digit above it are zero.
  always_comb begin
    zero_above = '0;
    zero_run   = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_run      = zero_run & (mag_ext[4*i +: 4] == 4'h0);
      zero_above[i] = zero_run;
    end
  end

  assign blank = BLANK && (idx_q != '0) && zero_above[idx_q];

  always_comb begin
    seg = 7'b0000000;
    if (!blank) begin
      case (nib)
        4'h0:    seg = 7'b1110111;
        4'h1:    seg = 7'b0010010;
        4'h2:    seg = 7'b1011101;
        4'h3:    seg = 7'b1011011;
        4'h4:    seg = 7'b0111010;
        4'h5:    seg = 7'b1101011;
        4'h6:    seg = 7'b1101111;
        4'h7:    seg = 7'b1010010;
        4'h8:    seg = 7'b1111111;
        4'h9:    seg = 7'b1111011;
        4'hA:    seg = 7'b1111110;
        4'hB:    seg = 7'b0101111;
        4'hC:    seg = 7'b1100101;
        4'hD:    seg = 7'b0011111;
        4'hE:    seg = 7'b1101101;
        default: seg = 7'b1101100;
      endcase
    end
  end

  always_comb begin
    an        = '0;
    an[idx_q] = 1'b1;
  end

  assign bus.busy    = busy;
  assign bus.done    = done;
  assign bus.product = product_q;
  assign bus.seg     = seg;
  assign bus.an      = an;
  assign bus.dp      = sign_q & (idx_q == LastIdx);

endmodule

// File: tb/tb_seq_mulneg_disp.sv
// Directed bench for seq_mulneg_disp (WIDTH=4, DIGITS=2, REFRESH_DIV=4, BLANK=1) with a
// product scoreboard checked on every done pulse.
module tb_seq_mulneg_disp;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   passes = 0;
  int   cyc = 0;
  logic [7:0] exp_q[$];

  seq_mulneg_disp_if #(.WIDTH(4), .DIGITS(2)) bus ();

  seq_mulneg_disp #(
    .WIDTH(4), .DIGITS(2), .REFRESH_DIV(4), .BLANK(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  function automatic logic [7:0] model(input logic [3:0] a, input logic [3:0] b);
    logic signed [7:0] x, y;
    x = $signed(a);
    y = $signed(b);
    return x * y;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding product.
  always @(negedge clk) begin
    if (!rst && bus.done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", {24'h0, bus.product}, 32'hDEAD);
      end else begin
        chk("product", {24'h0, bus.product}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic do_mul(input logic [3:0] a, input logic [3:0] b);
    exp_q.push_back(model(a, b));
    bus.a = a;
    bus.b = b;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("busy_after_start", {31'h0, bus.busy}, 1);
    chk("done_early", {31'h0, bus.done}, 0);
    for (int i = 1; i < 4; i++) begin
      tick();
      chk("done_early", {31'h0, bus.done}, 0);
    end
    tick();
    chk("done_on_time", {31'h0, bus.done}, 1);
    chk("busy_in_fin", {31'h0, bus.busy}, 1);
    tick();
    chk("done_one_cycle", {31'h0, bus.done}, 0);
    chk("busy_idle", {31'h0, bus.busy}, 0);
  endtask

  task automatic check_digit(input int d, input logic [6:0] exp_seg, input logic exp_dp);
    logic [1:0] target;
    target = 2'b01 << d;
    for (int i = 0; i < 16 && bus.an !== target; i++) tick();
    chk("an_reached", {30'h0, bus.an}, {30'h0, target});
    chk($sformatf("seg_digit%0d", d), {25'h0, bus.seg}, {25'h0, exp_seg});
    chk($sformatf("dp_digit%0d", d), {31'h0, bus.dp}, {31'h0, exp_dp});
  endtask

  task automatic wait_done(output int at);
    at = -1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.done === 1'b1) begin
        at = cyc;
        break;
      end
    end
    chk("done_seen", {31'h0, at >= 0}, 1);
  endtask

  initial begin
    int t0, t1, t2;
    bus.start = 1'b0;
    bus.a = 4'h0;
    bus.b = 4'h0;
    tick();
    tick();
    chk("rst_busy", {31'h0, bus.busy}, 0);
    chk("rst_done", {31'h0, bus.done}, 0);
    chk("rst_product", {24'h0, bus.product}, 32'h00);
    chk("rst_an", {30'h0, bus.an}, 32'h1);
    chk("rst_seg", {25'h0, bus.seg}, 32'b1110111);
    chk("rst_dp", {31'h0, bus.dp}, 0);
    rst = 1'b0;

    // Scan: digit 0 for four cycles, then digit 1 (blanked, magnitude zero).
    for (int i = 0; i < 3; i++) tick();
    chk("scan_hold", {30'h0, bus.an}, 32'h1);
    tick();
    chk("scan_step", {30'h0, bus.an}, 32'h2);
    chk("scan_blank", {25'h0, bus.seg}, 32'h0);
    for (int i = 0; i < 4; i++) tick();
    chk("scan_wrap", {30'h0, bus.an}, 32'h1);

    // 3 * -2 = -6
    do_mul(4'h3, 4'hE);
    check_digit(0, 7'b1101111, 1'b0);
    check_digit(1, 7'b0000000, 1'b1);

    // -8 * -8 = 64
    do_mul(4'h8, 4'h8);
    check_digit(1, 7'b0111010, 1'b0);
    check_digit(0, 7'b1110111, 1'b0);

    // 0 * -5 = 0, no minus sign
    do_mul(4'h0, 4'hB);
    check_digit(1, 7'b0000000, 1'b0);
    check_digit(0, 7'b1110111, 1'b0);

    // 5 * -3 = -15: upper digit blanked but dp still lit
    do_mul(4'h5, 4'hD);
    check_digit(1, 7'b0000000, 1'b1);
    check_digit(0, 7'b1101100, 1'b0);

    // start held high: back-to-back 7*7, operands disturbed mid-CALC of the first
    for (int i = 0; i < 3; i++) exp_q.push_back(model(4'h7, 4'h7));
    bus.a = 4'h7;
    bus.b = 4'h7;
    bus.start = 1'b1;
    tick();
    bus.a = 4'h1;
    bus.b = 4'h1;
    tick();
    tick();
    bus.a = 4'h7;
    bus.b = 4'h7;
    wait_done(t0);
    wait_done(t1);
    wait_done(t2);
    bus.start = 1'b0;
    chk("held_period1", t1 - t0, 6);
    chk("held_period2", t2 - t1, 6);
    chk("held_product", {24'h0, bus.product}, 32'h31);
    tick();
    tick();

    // Reset two cycles into a multiply: abort without update
    bus.a = 4'h3;
    bus.b = 4'h3;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    chk("abort_busy", {31'h0, bus.busy}, 0);
    chk("abort_product", {24'h0, bus.product}, 32'h00);
    chk("abort_an", {30'h0, bus.an}, 32'h1);
    chk("abort_seg", {25'h0, bus.seg}, 32'b1110111);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.done !== 1'b0) chk("abort_no_done", {31'h0, bus.done}, 0);
    end
    chk("abort_product_hold", {24'h0, bus.product}, 32'h00);

    // -8 * 7 = -56 completes normally after the abort
    do_mul(4'h8, 4'h7);
    check_digit(1, 7'b1011011, 1'b1);
    check_digit(0, 7'b1111111, 1'b0);

    tick();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
